// File: rtl/flash_audio_sequencer.sv
// Flash-to-audio sequencer: reads 32-bit flash words and plays them out as 16-bit samples.
// Optional UNDERRUN_CNT_EN adds a saturating count of dropped sample ticks.
module flash_audio_sequencer #(
    parameter int unsigned       ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF,
    parameter int unsigned       DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              direction,
    input  logic              restart,
    input  logic              sample_tick,
    output logic              flash_read,
    input  logic              flash_waitrequest,
    output logic [ADDR_W-1:0] flash_address,
    input  logic [DATA_W-1:0] flash_readdata,
    input  logic              flash_readdatavalid,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic              wrapped
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int unsigned SW = DATA_W / 2;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitData,
        StOutFirst,
        StOutSecond
    } state_e;

    state_e            state;
    logic              restart_pending;
    logic              word_dir;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_dec;

    always_comb begin
        start_addr = direction ? '0 : LAST_ADDR;
        addr_inc   = (flash_address == LAST_ADDR) ? '0 : flash_address + ADDR_W'(1);
        addr_dec   = (flash_address == '0) ? LAST_ADDR : flash_address - ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= StIdle;
            flash_read      <= 1'b0;
            flash_address   <= '0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            playing         <= 1'b0;
            wrapped         <= 1'b0;
            restart_pending <= 1'b0;
            word_dir        <= 1'b0;
            word            <= '0;
        end else begin
            sample_valid <= 1'b0;
            wrapped      <= 1'b0;
            if (restart) begin
                restart_pending <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    // Idle has no word in flight, so a restart lands straight away.
                    if (restart || restart_pending) begin
                        flash_address   <= start_addr;
                        restart_pending <= 1'b0;
                    end
                    if (play) begin
                        state      <= StReq;
                        flash_read <= 1'b1;
                        playing    <= 1'b1;
                        word_dir   <= direction;
                    end
                end

                StReq: begin
                    if (!flash_waitrequest) begin
                        flash_read <= 1'b0;
                        state      <= StWaitData;
                    end
                end

                StWaitData: begin
                    if (flash_readdatavalid) begin
                        word  <= flash_readdata;
                        state <= StOutFirst;
                    end
                end

                StOutFirst: begin
                    if (sample_tick) begin
                        sample_out   <= word_dir ? word[SW-1:0] : word[2*SW-1:SW];
                        sample_valid <= 1'b1;
                        state        <= StOutSecond;
                    end
                end

                StOutSecond: begin
                    if (sample_tick) begin
                        sample_out   <= word_dir ? word[2*SW-1:SW] : word[SW-1:0];
                        sample_valid <= 1'b1;
                        word_dir     <= direction;
                        // A restart arriving on this very cycle stays pending for the next word.
                        if (restart_pending) begin
                            flash_address   <= start_addr;
                            restart_pending <= restart;
                        end else if (direction) begin
                            flash_address <= addr_inc;
                            wrapped       <= (flash_address == LAST_ADDR);
                        end else begin
                            flash_address <= addr_dec;
                            wrapped       <= (flash_address == '0);
                        end
                        if (play) begin
                            state      <= StReq;
                            flash_read <= 1'b1;
                        end else begin
                            state   <= StIdle;
                            playing <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= StIdle;
                    flash_read <= 1'b0;
                    playing    <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic underrun;

    assign underrun = sample_tick &&
                      ((state == StIdle) || (state == StReq) || (state == StWaitData));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/flash_audio_sequencer.md
Name: flash_audio_sequencer

Overview:
Sequences word reads from the on-board flash for audio playback. Walks the flash address forward or backward between 0 and LAST_ADDR, wrapping at either end. Splits each 32-bit word into two 16-bit samples and releases one sample per sample_tick (22 kHz strobe) to the audio path. Sits between the flash Avalon-MM read port and the audio output and seconds-display logic; its flash_address/flash_readdatavalid feed the seconds counter.

Parameters:
ADDR_W, 23, flash word-address width
LAST_ADDR, 23'h7FFFF, last word address of the audio image
DATA_W, 32, flash read-data width; must be 2x sample width (16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause
direction  in  1  1 = forward (address increments), 0 = backward
restart  in  1  pulse; rewind to start of current direction
sample_tick  in  1  one-cycle strobe at sample rate
flash_read  out  1  Avalon read request
flash_waitrequest  in  1  Avalon waitrequest
flash_address  out  ADDR_W  word address of current/next read
flash_readdata  in  DATA_W  read data
flash_readdatavalid  in  1  read data valid strobe
sample_out  out  16  current audio sample, held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
playing  out  1  1 when not in IDLE
wrapped  out  1  one-cycle pulse when address wraps at either end

Behaviour:
- All state updates on posedge clk only. reset dominates every other input, in every state.
- Reset values: flash_read=0, flash_address=0, sample_out=0, sample_valid=0, playing=0, wrapped=0, state=IDLE, restart_pending=0, word register=0.
- States: IDLE, REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND.
- Word boundary: the cycle in which the FSM leaves IDLE or OUT_SECOND. play, direction and restart_pending are sampled only there.
- IDLE: playing=0. If play=1, go to REQ.
- REQ: flash_read=1 with flash_address stable. Stay while flash_waitrequest=1. When waitrequest=0, deassert flash_read next cycle and go to WAIT_DATA.
- WAIT_DATA: wait for flash_readdatavalid. On the valid cycle, latch flash_readdata and go to OUT_FIRST.
- OUT_FIRST: on sample_tick, output the first half-word and go to OUT_SECOND.
  - Forward: first half = readdata[15:0].
  - Backward: first half = readdata[31:16].
- OUT_SECOND: on sample_tick, output the other half-word and advance the address.
  - Forward: address+1; LAST_ADDR wraps to 0.
  - Backward: address-1; 0 wraps to LAST_ADDR.
  - On wrap, pulse wrapped in the same cycle as the address update.
  - Then: if play=1 go to REQ, else go to IDLE.
- sample_out and sample_valid update in the cycle after the consuming tick (1-cycle latency).
- sample_tick in IDLE/REQ/WAIT_DATA is an underrun. The tick is dropped; sample_out holds its value and sample_valid stays 0.
- sample_tick and flash_readdatavalid in the same cycle: data is latched, the tick is dropped (underrun).
- restart:
  - Sets restart_pending in any state.
  - At the next word boundary, the address loads 0 (direction=1) or LAST_ADDR (direction=0) instead of advancing. restart_pending clears.
  - No wrapped pulse for a restart load.
  - In IDLE, restart applies immediately.
  - An outstanding flash read is never aborted.
- Direction change mid-word: takes effect at the next word boundary. The current word finishes in its original half order.
- flash_address is only modified at word boundaries or on reset, never while flash_read=1.

Optional Feature:
- Macro: UNDERRUN_CNT_EN.
- When defined:
  - Adds output port underrun_count [15:0].
  - Counts sample_tick occurrences dropped per the underrun rules; saturates at 16'hFFFF.
  - Cleared by reset or restart.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, play=1, direction=1, waitrequest=0, data 32'hAAAA5555 at address 0 -> flash_read at address 0; first tick gives sample_out=16'h5555, second gives 16'hAAAA; next read at address 1.
- Forward at LAST_ADDR=23'h7FFFF, two ticks -> address becomes 0, wrapped pulses once, next read at address 0.
- direction=0 at address 0, data 32'h12345678 -> samples 16'h1234 then 16'h5678; address becomes 23'h7FFFF with wrapped=1.
- flash_waitrequest held high 5 cycles -> flash_read and flash_address stable all 5 cycles; exactly one read accepted.
- restart pulsed in WAIT_DATA at address 23'h00100 (forward) -> current word's two samples still output; next read at address 0; wrapped stays 0.
- sample_tick in WAIT_DATA -> no sample_valid, sample_out unchanged; with UNDERRUN_CNT_EN, underrun_count increments 0->1.
